// File: rtl/adder_pkg.sv
// Shared types and constants for the serial chunk adder.
package adder_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle: master supplies operands and consumes results.
interface serial_chunk_adder_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder; also reports the carry into its MSB for overflow detection.
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] full;

    assign full   = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    assign s_o    = full[CHUNK-1:0];
    assign cout_o = full[CHUNK];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the XOR.
    assign cmsb_o = s_o[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: latches operands, adds CHUNK bits per cycle, holds the result until taken.
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CHUNK = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_chunk_adder_if.slave bus
);

    localparam int unsigned NChunk = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int unsigned CntW   = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NChunk - 1);

    if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
        $error("serial_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
    if ($bits(bus.sum) != WIDTH) begin : g_bad_bus
        $error("serial_chunk_adder: interface WIDTH does not match module WIDTH");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d, ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [31:0]       idx;
    logic [CHUNK-1:0]  ca_s;
    logic              ca_cout, ca_cmsb;

    assign idx = 32'(cnt_q) * CHUNK;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i    (a_q[idx +: CHUNK]),
        .b_i    (b_q[idx +: CHUNK]),
        .cin_i  (carry_q),
        .s_o    (ca_s),
        .cout_o (ca_cout),
        .cmsb_o (ca_cmsb)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d        = bus.a;
                    b_d        = bus.b;
                    carry_d    = bus.cin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                sum_d[idx +: CHUNK] = ca_s;
                carry_d             = ca_cout;
                cnt_d               = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    cout_d      = ca_cout;
                    ovf_d       = ca_cmsb ^ ca_cout;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                // No accept on the handoff cycle: in_ready only rises once back in idle.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;

endmodule
